multibuffer_write_arbiter: RTL and testbench
============================================

// Module: multibuffer_write_arbiter
// PURPOSE
//  Shares the single write port of the multibuffer queue among NUM_REQ producers.
//  Grants are round-robin, in bursts of up to BURST_LEN beats.
//  A new burst starts only while the queue is not almost_full, so a granted burst can run to completion.
//  Sits between the producer DMA engines and the queue's write_en/data_in/waitrequest/almost_full pins.
// PARAMETERS
//  NUM_REQ     4    number of requesters (>=2)
//  DATA_WIDTH  128  beat width; equals queue Q_DATA_WIDTH
//  BURST_LEN   16   max beats per grant; power of 2, >=2
//  STAT_WIDTH  32   per-requester beat counter width (MBQ_ARB_STATS_EN only)
// PORTS
//  clk            in   1                   clock; all logic on posedge
//  rst_n          in   1                   asynchronous, active-low reset
//  req_valid      in   NUM_REQ             requester i has a beat on req_data[i]
//  req_data       in   NUM_REQ*DATA_WIDTH  packed beats; requester i at [i*DW +: DW]
//  req_accept     out  NUM_REQ             beat of requester i consumed this cycle
//  grant          out  NUM_REQ             registered one-hot owner; all-zero when idle
//  q_write_en     out  1                   to queue write_en
//  q_data_in      out  DATA_WIDTH          to queue data_in
//  q_waitrequest  in   1                   from queue waitrequest
//  q_almost_full  in   1                   from queue almost_full
//  stat_sel       in   clog2(NUM_REQ)      counter select (MBQ_ARB_STATS_EN only)
//  stat_count     out  STAT_WIDTH          selected beat count (MBQ_ARB_STATS_EN only)
// BEHAVIOUR
//  Reset (rst_n=0, async, any cycle incl. mid-burst):
//   state=IDLE, grant=0, rr_ptr=0, beat_cnt=0, stat counters=0.
//   req_accept=0, q_write_en=0 while in reset.
//  Combinational accept path:
//   req_accept = grant & req_valid & {NUM_REQ{~q_waitrequest}}.
//   q_write_en = |req_accept.
//   q_data_in  = req_data slice of the granted index; 0 when grant=0.
//   Beat transfers only when valid & grant & ~waitrequest all hold in the same cycle.
//   Requester holds req_data stable until accepted.
//  FSM, 2 states:
//   IDLE: if |req_valid && !q_almost_full:
//    - winner = first valid index at or after rr_ptr, wrapping modulo NUM_REQ.
//    - grant<=onehot(winner), beat_cnt<=0, go BURST.
//    - Otherwise stay IDLE with grant=0.
//   BURST: each accepted beat increments beat_cnt (width clog2(BURST_LEN)).
//    - End when the accepted beat has beat_cnt==BURST_LEN-1, or the owner has req_valid=0
//      while q_waitrequest=0 (producer ran dry).
//    - On end: grant<=0, rr_ptr<=(winner+1) mod NUM_REQ, go IDLE.
//  Grant latency: req_valid rises in cycle T -> grant in T+1 -> first accept no earlier than T+1.
//   The mandatory IDLE cycle between bursts costs one bubble per burst.
//  q_waitrequest high mid-burst: grant is held and beat_cnt frozen; the burst never ends on a stall.
//  q_almost_full is sampled only in IDLE; rising mid-burst has no effect.
//  Simultaneous requests: strict rotation. With all NUM_REQ valid, grants go 0,1,2,3,0.
//  A lone requester is re-granted after one IDLE cycle.
// CONFIGURATION
//  MBQ_ARB_STATS_EN defined:
//   - NUM_REQ counters of STAT_WIDTH bits, each incremented on req_accept[i].
//   - Counters wrap at 2^STAT_WIDTH; cleared only by reset.
//   - stat_count = counter[stat_sel], registered with 1-cycle latency.
//  MBQ_ARB_STATS_EN undefined: counters absent, stat_count tied 0, stat_sel ignored.
// STRUCTURE
//  Package mbq_arb_pkg:
//   - state encodings ST_IDLE=1'b0, ST_BURST=1'b1.
//   - onehot-to-index function.
//  Sub-module rr_priority_picker #(N):
//   - combinational; inputs req[N], ptr.
//   - outputs found, idx, onehot.
//   - reused by future read-side scheduler.
// TESTING
//  1. Reset mid-burst: assert rst_n=0 at beat 5 of requester 2 ->
//     grant=0, q_write_en=0 at once; after release, req0 wins first.
//  2. All 4 valid, waitrequest=0 -> grant order 0,1,2,3,0; each burst exactly 16 beats;
//     one idle cycle between bursts.
//  3. Owner drops valid after 3 beats -> burst ends, grant=0 next cycle, rr_ptr advances past owner.
//  4. q_waitrequest high for 10 cycles at beat 7 ->
//     grant held, no accept, beat_cnt=7 frozen; burst still totals 16 beats.
//  5. q_almost_full=1 with req1 valid in IDLE -> no grant until almost_full=0,
//     then grant=0010 next cycle.
//  6. MBQ_ARB_STATS_EN: 37 beats from req3, stat_sel=3 -> stat_count=37 one cycle later;
//     other counters 0.

Source files
------------

// File: rtl/mbq_arb_pkg.sv
// Shared types and helpers for the multibuffer queue write arbiter.
package mbq_arb_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_t;

   // Widest requester vector the helper below accepts.
   localparam int unsigned MAX_REQ = 32;

   // Index of the set bit of a one-hot vector; 0 when the vector is all-zero.
   function automatic int unsigned onehot_to_idx(input logic [MAX_REQ-1:0] onehot);
      int unsigned idx;
      idx = 0;
      for (int i = 0; i < int'(MAX_REQ); i++) begin
         if (onehot[i]) idx = unsigned'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N.
module rr_priority_picker #(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic                 found,
   output logic [$clog2(N)-1:0] idx,
   output logic [N-1:0]         onehot
);

   localparam int unsigned W = $clog2(N);

   // Scan from ptr upwards; the first hit wins.
   always_comb begin
      found  = 1'b0;
      idx    = '0;
      onehot = '0;
      for (int off = 0; off < int'(N); off++) begin
         if (!found && req[(int'(ptr) + off) % int'(N)]) begin
            found = 1'b1;
            idx   = W'((int'(ptr) + off) % int'(N));
            onehot[(int'(ptr) + off) % int'(N)] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/multibuffer_write_arbiter.sv
// Round-robin burst arbiter sharing the queue write port among NUM_REQ producers.
// Optional per-requester beat counters are built when MBQ_ARB_STATS_EN is defined.
module multibuffer_write_arbiter
   import mbq_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 128,
   parameter int unsigned BURST_LEN  = 16,
   parameter int unsigned STAT_WIDTH = 32
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_accept,
   output logic [NUM_REQ-1:0]            grant,
   output logic                          q_write_en,
   output logic [DATA_WIDTH-1:0]         q_data_in,
   input  logic                          q_waitrequest,
   input  logic                          q_almost_full,
   input  logic [$clog2(NUM_REQ)-1:0]    stat_sel,
   output logic [STAT_WIDTH-1:0]         stat_count
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);
   localparam int unsigned CNT_W = $clog2(BURST_LEN);

   state_t             state;
   logic [IDX_W-1:0]   rr_ptr;
   logic [CNT_W-1:0]   beat_cnt;
   logic [IDX_W-1:0]   owner;
   logic [IDX_W-1:0]   ptr_next;
   logic               burst_end;
   logic               pick_found;
   logic [IDX_W-1:0]   unused_pick_idx;
   logic [NUM_REQ-1:0] pick_onehot;

   rr_priority_picker #(
      .N (NUM_REQ)
   ) u_picker (
      .req    (req_valid),
      .ptr    (rr_ptr),
      .found  (pick_found),
      .idx    (unused_pick_idx),
      .onehot (pick_onehot)
   );

   // Accept path, data mux and end-of-burst detection.
   always_comb begin
      owner      = IDX_W'(onehot_to_idx(MAX_REQ'(grant)));
      ptr_next   = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
      req_accept = grant & req_valid & {NUM_REQ{~q_waitrequest}};
      q_write_en = |req_accept;
      q_data_in  = (|grant) ? req_data[int'(owner)*DATA_WIDTH +: DATA_WIDTH] : '0;
      // A stall never ends a burst; only the last beat or a dry owner does.
      burst_end  = (state == ST_BURST) &&
                   ((q_write_en && (beat_cnt == CNT_W'(BURST_LEN - 1))) ||
                    (!q_waitrequest && !(|(grant & req_valid))));
   end

   // Grant FSM: almost_full gates only the start of a burst.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         grant    <= '0;
         rr_ptr   <= '0;
         beat_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pick_found && !q_almost_full) begin
                  grant    <= pick_onehot;
                  beat_cnt <= '0;
                  state    <= ST_BURST;
               end
            end
            ST_BURST: begin
               if (burst_end) begin
                  grant  <= '0;
                  rr_ptr <= ptr_next;
                  state  <= ST_IDLE;
               end else if (q_write_en) begin
                  beat_cnt <= beat_cnt + 1'b1;
               end
            end
         endcase
      end
   end

`ifdef MBQ_ARB_STATS_EN
   logic [STAT_WIDTH-1:0] stat_cnt [NUM_REQ];

   // Per-requester accepted-beat counters (wrapping) and registered readout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(NUM_REQ); i++) stat_cnt[i] <= '0;
         stat_count <= '0;
      end else begin
         for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (req_accept[i]) stat_cnt[i] <= stat_cnt[i] + 1'b1;
         end
         stat_count <= stat_cnt[stat_sel];
      end
   end
`else
   logic unused_stat_sel;
   assign unused_stat_sel = ^stat_sel;
   assign stat_count      = '0;
`endif

endmodule

// File: tb/tb_multibuffer_write_arbiter.sv
// Self-checking bench for multibuffer_write_arbiter (default parameters).
module tb_multibuffer_write_arbiter;

   localparam int NR = 4;
   localparam int DW = 128;
   localparam int SW = 32;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [NR-1:0]    req_valid = '0;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0]    req_accept;
   logic [NR-1:0]    grant;
   logic             q_write_en;
   logic [DW-1:0]    q_data_in;
   logic             q_waitrequest = 1'b0;
   logic             q_almost_full = 1'b0;
   logic [1:0]       stat_sel = '0;
   logic [SW-1:0]    stat_count;

   int total = 0;
   int passed = 0;

   multibuffer_write_arbiter dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_data      (req_data),
      .req_accept    (req_accept),
      .grant         (grant),
      .q_write_en    (q_write_en),
      .q_data_in     (q_data_in),
      .q_waitrequest (q_waitrequest),
      .q_almost_full (q_almost_full),
      .stat_sel      (stat_sel),
      .stat_count    (stat_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] rv;
      logic       wr;
      logic       af;
      logic [3:0] g;
      logic [3:0] acc;
      logic       we;
      int         didx;
   } vec_t;

   vec_t tbl [15];

   function automatic logic [DW-1:0] data_of(input int i);
      logic [31:0] w;
      if (i < 0) return '0;
      w = 32'hD00D_0000 + 32'(i);
      return {4{w}};
   endfunction

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req_valid = '0;
      q_waitrequest = 1'b0;
      q_almost_full = 1'b0;
      stat_sel = '0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      bit ok;
      logic [3:0] oh;
      logic [SW-1:0] exp_stat;

      for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = data_of(i);

      // Reset state.
      @(negedge clk);
      req_valid = 4'b1111;
      #1;
      check("reset grant", grant, 0);
      check("reset accept", req_accept, 0);
      check("reset write_en", q_write_en, 0);
      check("reset stat", stat_count, 0);

      // Table-driven: almost_full gating, stalls, dry owner, rotation pointer.
      tbl[0]  = '{4'b0010, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, -1};
      tbl[1]  = '{4'b0010, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, -1};
      tbl[2]  = '{4'b0010, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, -1};
      tbl[3]  = '{4'b0010, 1'b0, 1'b0, 4'b0010, 4'b0010, 1'b1, 1};
      tbl[4]  = '{4'b0010, 1'b1, 1'b0, 4'b0010, 4'b0000, 1'b0, 1};
      tbl[5]  = '{4'b0010, 1'b0, 1'b1, 4'b0010, 4'b0010, 1'b1, 1};
      tbl[6]  = '{4'b0000, 1'b0, 1'b0, 4'b0010, 4'b0000, 1'b0, 1};
      tbl[7]  = '{4'b1111, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, -1};
      tbl[8]  = '{4'b1111, 1'b0, 1'b0, 4'b0100, 4'b0100, 1'b1, 2};
      tbl[9]  = '{4'b0000, 1'b0, 1'b0, 4'b0100, 4'b0000, 1'b0, 2};
      tbl[10] = '{4'b0011, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, -1};
      tbl[11] = '{4'b0011, 1'b0, 1'b0, 4'b0001, 4'b0001, 1'b1, 0};
      tbl[12] = '{4'b0000, 1'b1, 1'b0, 4'b0001, 4'b0000, 1'b0, 0};
      tbl[13] = '{4'b0000, 1'b0, 1'b0, 4'b0001, 4'b0000, 1'b0, 0};
      tbl[14] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, -1};

      do_reset();
      for (int k = 0; k < 15; k++) begin
         req_valid = tbl[k].rv;
         q_waitrequest = tbl[k].wr;
         q_almost_full = tbl[k].af;
         #1;
         check($sformatf("v%0d grant", k), grant, tbl[k].g);
         check($sformatf("v%0d accept", k), req_accept, tbl[k].acc);
         check($sformatf("v%0d write_en", k), q_write_en, tbl[k].we);
         check($sformatf("v%0d data", k), q_data_in, data_of(tbl[k].didx));
         tick();
      end

      // Reset in the middle of a burst of requester 2.
      do_reset();
      req_valid = 4'b0100;
      tick();
      for (int b = 0; b < 5; b++) tick();
      #1;
      check("midrst beat5 accept", req_accept, 4'b0100);
      rst_n = 1'b0;
      #1;
      check("midrst grant", grant, 0);
      check("midrst write_en", q_write_en, 0);
      check("midrst accept", req_accept, 0);
      req_valid = 4'b1111;
      tick();
      rst_n = 1'b1;
      #1;
      check("midrst idle after release", grant, 0);
      tick();
      #1;
      check("midrst first winner", grant, 4'b0001);

      // All four valid: 0,1,2,3,0, 16 beats each, one idle cycle between.
      do_reset();
      req_valid = 4'b1111;
      for (int b = 0; b < 5; b++) begin
         ok = 1'b1;
         oh = 4'b0001 << (b % 4);
         #1;
         if (grant !== 4'b0000) ok = 1'b0;
         tick();
         for (int c = 0; c < 16; c++) begin
            #1;
            if (grant !== oh || req_accept !== oh) ok = 1'b0;
            tick();
         end
         check($sformatf("rotation burst %0d ok", b), ok, 1);
      end

      // Owner runs dry after 3 beats; pointer moves past it.
      do_reset();
      req_valid = 4'b1111;
      tick();
      for (int c = 0; c < 3; c++) tick();
      req_valid = 4'b0010;
      #1;
      check("dry grant held", grant, 4'b0001);
      check("dry no accept", req_accept, 0);
      tick();
      req_valid = 4'b0011;
      #1;
      check("dry grant dropped", grant, 0);
      tick();
      #1;
      check("dry next winner", grant, 4'b0010);

      // Ten-cycle stall at beat 7.
      do_reset();
      req_valid = 4'b0001;
      tick();
      n = 0;
      for (int c = 0; c < 7; c++) begin
         #1;
         if (req_accept[0]) n++;
         tick();
      end
      check("stall pre beats", n, 7);
      q_waitrequest = 1'b1;
      ok = 1'b1;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (grant !== 4'b0001 || req_accept !== 4'b0000) ok = 1'b0;
         tick();
      end
      check("stall grant held no accept", ok, 1);
      check("stall beat_cnt frozen", dut.beat_cnt, 7);
      q_waitrequest = 1'b0;
      for (int c = 0; c < 30; c++) begin
         #1;
         if (grant === 4'b0000) break;
         if (req_accept[0]) n++;
         tick();
      end
      check("stall burst total", n, 16);
      check("stall idle after burst", grant, 0);
      tick();
      #1;
      check("lone requester regrant", grant, 4'b0001);

      // Beat counters: 37 beats from requester 3.
      do_reset();
      req_valid = 4'b1000;
      stat_sel = 2'd3;
      n = 0;
      for (int c = 0; c < 200 && n < 37; c++) begin
         #1;
         if (req_accept[3]) n++;
         tick();
      end
      req_valid = 4'b0000;
      check("stat beats driven", n, 37);
      tick();
      tick();
      #1;
`ifdef MBQ_ARB_STATS_EN
      exp_stat = 37;
`else
      exp_stat = 0;
`endif
      check("stat req3", stat_count, exp_stat);
      for (int s = 0; s < 3; s++) begin
         stat_sel = 2'(s);
         tick();
         #1;
         check($sformatf("stat req%0d", s), stat_count, 0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
